// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - address map and STATUS layout for the data-memory responder
package dmem_pkg;

  localparam logic [31:0] ADDR_CONSOLE_DATA = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS       = 32'h1000_0004;
  localparam logic [31:0] ADDR_CYCLES       = 32'h1000_0008;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  // Word-granular match: the byte offset bits never take part in decode.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - console transmit FIFO with occupancy count
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the slot in the same edge.
  assign do_push  = push & (~full | do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-port responder: word RAM, console FIFO, STATUS, CYCLES
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bad_access
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ram, is_con, is_st, is_cyc, is_unmapped;
  logic              fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic [31:0]       cycles;
  logic [31:0]       status;
  logic              unused_addr;

  assign unused_addr = &{1'b0, address[1:0]};
  assign ram_idx     = address[RAM_AW+1:2];
  assign is_ram      = (address[31:RAM_AW+2] == '0);
  assign is_con      = addr_hit(address, ADDR_CONSOLE_DATA);
  assign is_st       = addr_hit(address, ADDR_STATUS);
  assign is_cyc      = addr_hit(address, ADDR_CYCLES);
  assign is_unmapped = ~(is_ram | is_con | is_st | is_cyc);

  assign push     = write_enable & is_con;
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;

  console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .data_in  (write_data[7:0]),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (tx_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Gated by reset so a store landing on the same edge as reset is lost.
  always_ff @(posedge clock) begin
    if (reset && write_enable && is_ram) ram[ram_idx] <= write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      cycles     <= '0;
      bad_access <= 1'b0;
    end else begin
      if (push && fifo_full && !pop)                       overflow <= 1'b1;
      else if (write_enable && is_st && write_data[ST_OVF]) overflow <= 1'b0;
      cycles     <= (write_enable && is_cyc) ? write_data : cycles + 32'd1;
      bad_access <= write_enable & is_unmapped;
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_FULL]          = fifo_full;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_OVF]           = overflow;
    status[ST_CNT_LSB +: CW] = fifo_count;
  end

  always_comb begin
    read_data = '0;
    if (is_ram)      read_data = ram[ram_idx];
    else if (is_st)  read_data = status;
    else if (is_cyc) read_data = cycles;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bad_access;

  always #5 clock = ~clock;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .bad_access   (bad_access)
  );

  typedef struct { string name; logic [31:0] val; } exp_t;
  exp_t       rd_q[$];
  exp_t       tv_q[$];
  exp_t       ba_q[$];
  logic [7:0] tx_q[$];
  logic       rd_chk = 1'b0, tv_chk = 1'b0, ba_chk = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic compare(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic missing(input string n);
    total++;
    bad++;
    $display("FAIL %s: output seen with no expected entry", n);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rd_chk) begin
      if (rd_q.size() == 0) missing("read_data");
      else begin e = rd_q.pop_front(); compare(e.name, read_data, e.val); end
    end
    if (tv_chk) begin
      if (tv_q.size() == 0) missing("tx_port");
      else begin e = tv_q.pop_front(); compare(e.name, {23'b0, tx_valid, tx_data}, e.val); end
    end
    if (ba_chk) begin
      if (ba_q.size() == 0) missing("bad_access");
      else begin e = ba_q.pop_front(); compare(e.name, {31'b0, bad_access}, e.val); end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) missing("tx_beat");
      else compare("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic chk, input logic [31:0] e, input string n);
    address = a; write_data = d; write_enable = we;
    if (chk) begin rd_q.push_back(exp_t'{name: n, val: e}); rd_chk = 1'b1; end
    @(posedge clock); #1;
    write_enable = 1'b0; rd_chk = 1'b0; tv_chk = 1'b0; ba_chk = 1'b0;
  endtask

  task automatic exp_tx(input string n, input logic v, input logic [7:0] d);
    tv_q.push_back(exp_t'{name: n, val: {23'b0, v, d}});
    tv_chk = 1'b1;
  endtask

  task automatic exp_ba(input string n, input logic v);
    ba_q.push_back(exp_t'{name: n, val: {31'b0, v}});
    ba_chk = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] unmapped [2];
    unmapped[0] = 32'h2000_0000;
    unmapped[1] = 32'h0000_1000;

    @(posedge clock); #1;
    exp_tx("rst_tx", 1'b0, 8'h00);
    exp_ba("rst_bad", 1'b0);
    cyc(ADDR_STATUS, 0, 0, 1, 32'h2, "rst_status");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'h0, "rst_cycles");
    reset = 1'b1;

    // RAM store/load, same-cycle read returns old data, top word, mapped store is not bad
    cyc(32'h10, 32'h1111_1111, 1, 0, 0, "");
    cyc(32'h10, 32'hDEAD_BEEF, 1, 1, 32'h1111_1111, "ram_rdw_old");
    exp_ba("ram_store_ok", 1'b0);
    cyc(32'h10, 0, 0, 1, 32'hDEAD_BEEF, "ram_rd_10");
    cyc(32'h13, 0, 0, 1, 32'hDEAD_BEEF, "ram_rd_13");
    cyc(32'hFFC, 32'hCAFE_F00D, 1, 0, 0, "");
    cyc(32'hFFF, 0, 0, 1, 32'hCAFE_F00D, "ram_rd_top");

    // Unmapped stores: one-cycle bad_access, loads read 0
    foreach (unmapped[i]) begin
      cyc(unmapped[i], 32'h5, 1, 1, 32'h0, "unmapped_rd");
      exp_ba("bad_pulse", 1'b1);
      cyc(unmapped[i], 0, 0, 1, 32'h0, "unmapped_rd2");
      exp_ba("bad_clear", 1'b0);
      cyc(0, 0, 0, 0, 0, "");
    end

    // Fill with ready low: nine pushes, the ninth overflows
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'(8'h41 + i));
      cyc(ADDR_CONSOLE_DATA, 32'h41 + i, 1, 1, 32'h0, "con_rd_zero");
    end
    exp_tx("full_head", 1'b1, 8'h41);
    cyc(ADDR_STATUS, 0, 0, 1, 32'h805, "status_full_ovf");
    tx_ready = 1'b1;
    cyc(ADDR_STATUS, 0, 0, 1, 32'h805, "status_pre_pop");
    repeat (7) cyc(0, 0, 0, 0, 0, "");
    exp_tx("drained", 1'b0, 8'h00);
    cyc(ADDR_STATUS, 0, 0, 1, 32'h6, "status_empty_ovf");

    // Overflow clear, same-cycle read sees old value
    cyc(ADDR_STATUS, 32'h4, 1, 1, 32'h6, "status_clr_old");
    cyc(ADDR_STATUS, 0, 0, 1, 32'h2, "status_clr");

    // Full FIFO with simultaneous push and pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'(8'h61 + i));
      cyc(ADDR_CONSOLE_DATA, 32'h61 + i, 1, 0, 0, "");
    end
    cyc(ADDR_STATUS, 0, 0, 1, 32'h801, "status_full");
    tx_ready = 1'b1;
    tx_q.push_back(8'h5A);
    cyc(ADDR_CONSOLE_DATA, 32'h5A, 1, 0, 0, "");
    tx_ready = 1'b0;
    exp_tx("hold_head", 1'b1, 8'h62);
    cyc(ADDR_STATUS, 0, 0, 1, 32'h801, "status_pushpop");
    tx_ready = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, "");
    exp_tx("drained2", 1'b0, 8'h00);
    cyc(ADDR_STATUS, 0, 0, 1, 32'h2, "status_empty");

    // Cycle counter load, wrap, load-vs-read in same cycle
    cyc(ADDR_CYCLES, 32'hFFFF_FFFE, 1, 0, 0, "");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'hFFFF_FFFE, "cyc_fe");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'hFFFF_FFFF, "cyc_ff");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'h0, "cyc_wrap");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'h1, "cyc_one");
    cyc(ADDR_CYCLES, 32'h100, 1, 1, 32'h2, "cyc_rdw_old");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'h100, "cyc_loaded");

    // Reset pulled mid-drain
    tx_ready = 1'b0;
    tx_q.push_back(8'h71);
    for (int i = 0; i < 3; i++) cyc(ADDR_CONSOLE_DATA, 32'h71 + i, 1, 0, 0, "");
    tx_ready = 1'b1;
    cyc(0, 0, 0, 0, 0, "");
    address = ADDR_STATUS;
    rd_q.push_back(exp_t'{name: "status_async_rst", val: 32'h2});
    rd_chk = 1'b1;
    exp_tx("tx_async_rst", 1'b0, 8'h00);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    rd_chk = 1'b0; tv_chk = 1'b0;
    cyc(32'h10, 32'h1234_5678, 1, 1, 32'hDEAD_BEEF, "ram_in_rst");
    cyc(ADDR_CYCLES, 0, 0, 1, 32'h0, "cyc_in_rst");
    reset = 1'b1;
    exp_ba("bad_after_rst", 1'b0);
    cyc(32'h10, 0, 0, 1, 32'hDEAD_BEEF, "ram_store_lost");
    tx_ready = 1'b0;
    cyc(0, 0, 0, 0, 0, "");

    compare("tx_left", tx_q.size(), 0);
    compare("rd_left", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
